// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only LCD controller:
// FSM state encoding, command bytes and the power-up init ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR   = 3'd0,
        IDLE  = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4,
        WAIT  = 3'd5
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;

    localparam int         INIT_LEN  = 6;
    localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

    // Entry 0 is written first.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        LCD_ENTRY_INC, LCD_CLEAR, LCD_DISP_ON,
        LCD_FUNC_8B2L, LCD_FUNC_8B2L, LCD_FUNC_8B2L
    };

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:1] == 7'b000_0000 || data[7:1] == 7'b000_0001);
    endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write controller: power-up init, then (rs,data) writes
// over valid/ready with E-pulse setup/width/hold and execution-wait timing.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 405000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 13,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 1100,
    parameter int unsigned T_LONG  = 44500,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on
);

    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             on_q, on_d;

    logic             cnt_zero;
    logic [2:0]       idx_next;

    assign cnt_zero = (cnt_q == '0);
    assign idx_next = idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        idx_d   = idx_q;
        done_d  = done_q;
        data_d  = data_q;
        rs_d    = rs_q;
        on_d    = 1'b1;

        case (state_q)
            // The first cycle out of reset (lcd_on still low) arms the power-up wait.
            PWR: begin
                if (!on_q) begin
                    cnt_d = LD_PWRUP;
                end else if (cnt_zero) begin
                    state_d = SETUP;
                    cnt_d   = LD_SETUP;
                    idx_d   = 3'd0;
                    data_d  = INIT_ROM[0];
                    rs_d    = 1'b0;
                end
            end
            IDLE: begin
                if (req_valid && done_q) begin
                    state_d = SETUP;
                    cnt_d   = LD_SETUP;
                    data_d  = req_data;
                    rs_d    = req_rs;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = PULSE;
                    cnt_d   = LD_EN;
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_d = HOLD;
                    cnt_d   = LD_HOLD;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_d = WAIT;
                    cnt_d   = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_EXEC;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    if (done_q) begin
                        state_d = IDLE;
                    end else if (idx_q == INIT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = LD_SETUP;
                        idx_d   = idx_next;
                        data_d  = INIT_ROM[idx_next];
                        rs_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = PWR;
                cnt_d   = '0;
            end
        endcase

        en_d = (state_d == PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PWR;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            on_q    <= on_d;
        end
    end

    assign req_ready = (state_q == IDLE) && done_q;
    assign busy      = (state_q != IDLE);
    assign init_done = done_q;
    assign lcd_data  = data_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = en_q;
    assign lcd_on    = on_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench for lcd_hd44780_ctrl with shortened timing parameters;
// every E pulse is checked against a queue of expected (rs,data) writes.
module tb_lcd_hd44780_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       init_done, busy;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulses = 0;

    logic [8:0] exp_q[$];

    lcd_hd44780_ctrl #(
        .T_PWRUP(20), .T_SETUP(2), .T_EN(3), .T_HOLD(2),
        .T_EXEC(10), .T_LONG(40), .CNT_W(20)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_data(req_data),
        .init_done(init_done), .busy(busy),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en), .lcd_on(lcd_on)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_init_timeout"}, init_done, 1'b1);
    endtask

    // Single write from IDLE; busy_len is the number of busy samples after accept.
    task automatic do_write(input logic rs, input logic [7:0] data, input int busy_len);
        int n = 0;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = data;
        exp_q.push_back({rs, data});
        chk("ready_before", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        while (busy && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("busy_len_%0d_%02h", rs, data), n, busy_len);
    endtask

    // Monitor: protocol rules plus scoreboard pop on every E rise.
    logic       en_prev = 1'b0;
    logic [8:0] hist1 = '0, hist2 = '0, cap = '0;
    int         en_len = 0;
    int         hold_left = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev   = 1'b0;
            hold_left = 0;
            en_len    = 0;
            hist1     = '0;
            hist2     = '0;
        end else begin
            chk("rw_zero", lcd_rw, 1'b0);
            chk("ready_implies_idle_done", req_ready && (busy || !init_done), 1'b0);
            if (lcd_en && !en_prev) begin
                n_pulses++;
                chk("setup_stable", hist2, {lcd_rs, lcd_data});
                if (exp_q.size() == 0) chk("sb_unexpected_pulse", 1, 0);
                else chk("sb_byte", {lcd_rs, lcd_data}, exp_q.pop_front());
                cap    = {lcd_rs, lcd_data};
                en_len = 1;
            end else if (lcd_en) begin
                chk("en_stable", {lcd_rs, lcd_data}, cap);
                en_len++;
            end
            if (!lcd_en && en_prev) begin
                chk("en_width", en_len, 3);
                hold_left = 2;
            end
            if (hold_left > 0 && !lcd_en) begin
                chk("hold_stable", {lcd_rs, lcd_data}, cap);
                hold_left--;
            end
            hist2   = hist1;
            hist1   = {lcd_rs, lcd_data};
            en_prev = lcd_en;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        logic prev_busy;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_lcd_on", lcd_on, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_en", lcd_en, 1'b0);
        chk("rst_data", {lcd_rs, lcd_data}, 9'h000);

        // Power-up init sequence
        push_init();
        p0 = n_pulses;
        rst_n = 1'b1;
        @(negedge clk);
        chk("lcd_on_after_release", lcd_on, 1'b1);
        n = 0;
        while (!lcd_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("first_en_delay", n, 22);
        wait_init("pwrup");
        chk("init_pulses", n_pulses - p0, 6);
        chk("init_queue_empty", exp_q.size(), 0);

        // Normal writes and execution-wait lengths
        do_write(1'b1, 8'h41, 17);
        do_write(1'b0, 8'h01, 47);
        do_write(1'b1, 8'h01, 17);
        do_write(1'b0, 8'h02, 47);
        do_write(1'b0, 8'h03, 47);
        do_write(1'b0, 8'h04, 17);
        chk("writes_queue_empty", exp_q.size(), 0);

        // Valid held from reset release; two queued writes
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("rst2_init_done", init_done, 1'b0);
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h55;
        push_init();
        exp_q.push_back({1'b1, 8'h55});
        p0 = n_pulses;
        rst_n = 1'b1;
        prev_busy = 1'b1;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (req_ready) break;
            prev_busy = busy;
        end
        chk("held_ready_seen", req_ready, 1'b1);
        chk("held_accept_after_init", init_done, 1'b1);
        chk("held_first_idle_cycle", prev_busy, 1'b1);
        @(negedge clk);
        req_data = 8'h5A;
        exp_q.push_back({1'b1, 8'h5A});
        n = 1;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_interval", n, 18);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("held_idle_timeout", busy, 1'b0);
        chk("held_pulses", n_pulses - p0, 8);
        chk("held_queue_empty", exp_q.size(), 0);

        // Reset while E is high
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h48;
        exp_q.push_back({1'b1, 8'h48});
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!lcd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midpulse_en_seen", lcd_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midpulse_en_drop", lcd_en, 1'b0);
        chk("midpulse_init_done", init_done, 1'b0);
        chk("midpulse_busy", busy, 1'b1);
        chk("midpulse_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_init();
        p0 = n_pulses;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("restart_init_done_low", init_done, 1'b0);
        wait_init("restart");
        chk("restart_pulses", n_pulses - p0, 6);
        chk("restart_queue_empty", exp_q.size(), 0);
        do_write(1'b1, 8'h7E, 17);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
